// File: rtl/shr_serial_rx_if.sv
// Serial loopback lines plus the capture results of shr_serial_rx.
// master drives the serial lines and expect_len; slave is the receiver.
interface shr_serial_rx_if #(
   parameter int unsigned MAX_BITS = 1024,
   parameter int unsigned CNT_W    = 11
);
   logic                ser_clk;
   logic                ser_din;
   logic                ser_syn;
   logic [CNT_W-1:0]    expect_len;
   logic [MAX_BITS-1:0] data_out;
   logic [CNT_W-1:0]    bit_cnt;
   logic                busy;
   logic                frame_done;
   logic                frame_ok;
   logic                len_err;
   logic                ovf;

   modport master (
      output ser_clk, ser_din, ser_syn, expect_len,
      input  data_out, bit_cnt, busy, frame_done, frame_ok, len_err, ovf
   );

   modport slave (
      input  ser_clk, ser_din, ser_syn, expect_len,
      output data_out, bit_cnt, busy, frame_done, frame_ok, len_err, ovf
   );
endinterface

// File: rtl/shr_serial_rx.sv
// Oversampling receiver for SYNC/CLK/DIN shift-register frames: deserializes
// each frame captured while SYNC is low and checks its length.
module shr_serial_rx #(
   parameter int unsigned MAX_BITS    = 1024,
   parameter int unsigned CNT_W       = 11,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic            clk_in,
   input logic            rst,
   shr_serial_rx_if.slave bus
);
   localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BITS);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   logic [SYNC_STAGES-1:0] clk_sync, din_sync, syn_sync;
   logic                   clk_prev, syn_prev;
   logic                   clk_s, din_s, syn_s;
   logic                   clk_rise, syn_fall, syn_rise;

   state_e state_q, state_d;
   logic   busy, frame_start, capture, finish, len_bad;

   logic [MAX_BITS-1:0] data_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                frame_done_q, frame_ok_q, len_err_q, ovf_q;

   // Preset to the idle-high level so releasing reset never looks like an edge.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         clk_sync <= '1;
         din_sync <= '1;
         syn_sync <= '1;
         clk_prev <= 1'b1;
         syn_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.ser_clk};
         din_sync <= {din_sync[SYNC_STAGES-2:0], bus.ser_din};
         syn_sync <= {syn_sync[SYNC_STAGES-2:0], bus.ser_syn};
         clk_prev <= clk_sync[SYNC_STAGES-1];
         syn_prev <= syn_sync[SYNC_STAGES-1];
      end
   end

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign din_s    = din_sync[SYNC_STAGES-1];
   assign syn_s    = syn_sync[SYNC_STAGES-1];
   assign clk_rise = clk_s & ~clk_prev;
   assign syn_fall = ~syn_s & syn_prev;
   assign syn_rise = syn_s & ~syn_prev;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (syn_fall) state_d = StShift;
         StShift: if (syn_rise) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      frame_start = 1'b0;
      capture     = 1'b0;
      finish      = 1'b0;
      unique case (state_q)
         StIdle:  frame_start = syn_fall;
         StShift: begin
            busy    = 1'b1;
            // syn_s high here means the frame is closing; that edge is dropped.
            capture = clk_rise & ~syn_s;
         end
         StDone:  finish = 1'b1;
         default: ;
      endcase
   end

   assign len_bad = (bus.expect_len != '0) && (cnt_q != bus.expect_len);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         data_q       <= '0;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         len_err_q    <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         frame_done_q <= finish;
         if (frame_start) begin
            data_q     <= '0;
            cnt_q      <= '0;
            frame_ok_q <= 1'b0;
            len_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
         end else if (capture) begin
            if (cnt_q < MaxCnt) begin
               data_q <= {data_q[MAX_BITS-2:0], din_s};
               cnt_q  <= cnt_q + CNT_W'(1);
            end else begin
               ovf_q <= 1'b1;
            end
         end else if (finish) begin
            len_err_q  <= len_bad;
            frame_ok_q <= ~len_bad & ~ovf_q;
         end
      end
   end

   assign bus.data_out   = data_q;
   assign bus.bit_cnt    = cnt_q;
   assign bus.busy       = busy;
   assign bus.frame_done = frame_done_q;
   assign bus.frame_ok   = frame_ok_q;
   assign bus.len_err    = len_err_q;
   assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_shr_serial_rx.sv
// Scoreboard bench for shr_serial_rx: frames push their expected result, a
// monitor pops and compares on every frame_done pulse.
module tb_shr_serial_rx;
   localparam int unsigned MaxBits = 1024;
   localparam int unsigned CntW    = 11;

   typedef struct {
      logic [MaxBits-1:0] data;
      logic [CntW-1:0]    cnt;
      logic               ok;
      logic               lerr;
      logic               ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   done_seen = 0;
   exp_t sb[$];

   shr_serial_rx_if #(.MAX_BITS(MaxBits), .CNT_W(CntW)) bus ();

   shr_serial_rx #(.MAX_BITS(MaxBits), .CNT_W(CntW), .SYNC_STAGES(2)) dut (
      .clk_in (clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [MaxBits-1:0] d, input logic [CntW-1:0] c,
                               input logic ok, input logic lerr, input logic ovf);
      exp_t e;
      e.data = d;
      e.cnt  = c;
      e.ok   = ok;
      e.lerr = lerr;
      e.ovf  = ovf;
      return e;
   endfunction

   // Monitor: every frame_done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.frame_done) begin
         exp_t e;
         done_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done: got pulse expected none");
         end else begin
            e = sb.pop_front();
            checks++;
            if (bus.data_out !== e.data) begin
               errors++;
               $display("FAIL data_out: got low64 %0h expected low64 %0h",
                        bus.data_out[63:0], e.data[63:0]);
            end
            chk("bit_cnt", 64'(bus.bit_cnt), 64'(e.cnt));
            chk("frame_ok", 64'(bus.frame_ok), 64'(e.ok));
            chk("len_err", 64'(bus.len_err), 64'(e.lerr));
            chk("ovf", 64'(bus.ovf), 64'(e.ovf));
            chk("busy_at_done", 64'(bus.busy), 64'd0);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_data"}, 64'(bus.data_out != '0), 64'd0);
      chk({tag, "_cnt"}, 64'(bus.bit_cnt), 64'd0);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.frame_done), 64'd0);
      chk({tag, "_ok"}, 64'(bus.frame_ok), 64'd0);
      chk({tag, "_lerr"}, 64'(bus.len_err), 64'd0);
      chk({tag, "_ovf"}, 64'(bus.ovf), 64'd0);
   endtask

   task automatic send_bit(input logic b);
      bus.ser_din = b;
      repeat (4) @(negedge clk);
      bus.ser_clk = 1'b1;
      repeat (4) @(negedge clk);
      bus.ser_clk = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (sb.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL frame_done_timeout: got none after 40 cycles expected pulse");
         sb.delete();
      end
      @(negedge clk);
      chk("done_one_cycle", 64'(bus.frame_done), 64'd0);
   endtask

   // alt=1 sends bit i = i[0]; otherwise vec[n-1:0] MSB first.
   task automatic send_frame(input logic [MaxBits-1:0] vec, input int n, input bit alt,
                             input logic [CntW-1:0] elen, input exp_t e);
      bus.expect_len = elen;
      sb.push_back(e);
      @(negedge clk);
      bus.ser_syn = 1'b0;
      repeat (4) @(negedge clk);
      chk("start_busy", 64'(bus.busy), 64'd1);
      chk("start_lerr_clr", 64'(bus.len_err), 64'd0);
      chk("start_ok_clr", 64'(bus.frame_ok), 64'd0);
      chk("start_ovf_clr", 64'(bus.ovf), 64'd0);
      for (int i = 0; i < n; i++) begin
         send_bit(alt ? 1'(i & 1) : vec[n-1-i]);
      end
      repeat (4) @(negedge clk);
      bus.ser_syn = 1'b1;
      wait_drain();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen0;
      rst            = 1'b1;
      bus.ser_clk    = 1'b0;
      bus.ser_din    = 1'b0;
      bus.ser_syn    = 1'b1;
      bus.expect_len = '0;
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      rst = 1'b0;
      seen0 = done_seen;
      repeat (20) @(negedge clk);
      chk("no_done_after_reset", 64'(done_seen - seen0), 64'd0);
      check_all_zero("post_reset");

      send_frame(MaxBits'(10'b1011001110), 10, 1'b0, 11'd10,
                 mk(MaxBits'(10'b1011001110), 11'd10, 1'b1, 1'b0, 1'b0));
      send_frame(MaxBits'(10'b1011001110), 10, 1'b0, 11'd12,
                 mk(MaxBits'(10'b1011001110), 11'd10, 1'b0, 1'b1, 1'b0));
      send_frame(MaxBits'(10'b1011001110), 10, 1'b0, 11'd10,
                 mk(MaxBits'(10'b1011001110), 11'd10, 1'b1, 1'b0, 1'b0));
      // Bits 0..1023 alternate 0,1,...; last captured (bit 1023 = 1) lands at data_out[0].
      send_frame('0, 1030, 1'b1, 11'd0, mk({512{2'b01}}, 11'd1024, 1'b0, 1'b0, 1'b1));
      send_frame('0, 0, 1'b0, 11'd0, mk('0, 11'd0, 1'b1, 1'b0, 1'b0));
      send_frame('0, 0, 1'b0, 11'd5, mk('0, 11'd0, 1'b0, 1'b1, 1'b0));

      // Abandon a frame after 5 bits with reset.
      bus.expect_len = 11'd8;
      seen0 = done_seen;
      @(negedge clk);
      bus.ser_syn = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 5; i++) send_bit(1'(i & 1) ^ 1'b1);
      repeat (2) @(negedge clk);
      chk("mid_frame_cnt", 64'(bus.bit_cnt), 64'd5);
      rst         = 1'b1;
      bus.ser_syn = 1'b1;
      bus.ser_clk = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("mid_reset");
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_done_aborted", 64'(done_seen - seen0), 64'd0);

      send_frame(MaxBits'(8'hA5), 8, 1'b0, 11'd8, mk(MaxBits'(8'hA5), 11'd8, 1'b1, 1'b0, 1'b0));

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      chk("total_frames", 64'(done_seen), 64'd7);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
